// File: rtl/jpeg_idct_transpose_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jpeg_idct_transpose_if                                           |
// | Purpose  : Write-side and replay-side bus bundle of the IDCT transpose buf. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface jpeg_idct_transpose_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) ();
    logic             inport_valid_i;
    logic [IN_W-1:0]  inport_data_i;
    logic [5:0]       inport_idx_i;
    logic             inport_accept_o;

    logic             outport_valid_o;
    logic [OUT_W-1:0] outport_data0_o;
    logic [OUT_W-1:0] outport_data1_o;
    logic [OUT_W-1:0] outport_data2_o;
    logic [OUT_W-1:0] outport_data3_o;
    logic [2:0]       outport_idx_o;
    logic [2:0]       outport_col_o;
    logic             outport_accept_i;

    modport slave (
        input  inport_valid_i,
        input  inport_data_i,
        input  inport_idx_i,
        output inport_accept_o,
        output outport_valid_o,
        output outport_data0_o,
        output outport_data1_o,
        output outport_data2_o,
        output outport_data3_o,
        output outport_idx_o,
        output outport_col_o,
        input  outport_accept_i
    );

    modport master (
        output inport_valid_i,
        output inport_data_i,
        output inport_idx_i,
        input  inport_accept_o,
        input  outport_valid_o,
        input  outport_data0_o,
        input  outport_data1_o,
        input  outport_data2_o,
        input  outport_data3_o,
        input  outport_idx_o,
        input  outport_col_o,
        output outport_accept_i
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_idct_transpose.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jpeg_idct_transpose                                             |
// | Purpose  : Ping-pong 8x8 transpose buffer between row and column IDCT,     |
// |            replaying columns as 4 lanes x 8 beats. Optional saturation of  |
// |            lanes selected by JPEG_IDCT_TRANSPOSE_SAT_EN.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jpeg_idct_transpose #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 img_start_i,
    jpeg_idct_transpose_if.slave bus,
    output logic                 overflow_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] c_LAST_IDX  = 6'd63;
    localparam logic [2:0] c_LAST_BEAT = 3'd7;
    localparam logic [2:0] c_LAST_COL  = 3'd7;

    // Address = {bank, row, col}; words are narrowed on the way in.
    logic [OUT_W-1:0] mem_q [0:127];

    state_t           state_q, state_d;
    logic [1:0]       full_q, full_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [2:0]       col_q, col_d;
    logic [2:0]       beat_q, beat_d;
    logic             valid_q, valid_d;
    logic [2:0]       oidx_q, oidx_d;
    logic [2:0]       ocol_q, ocol_d;
    logic [OUT_W-1:0] lane_q [4];
    logic [OUT_W-1:0] lane_d [4];
    logic             ovf_q, ovf_d;

    logic [OUT_W-1:0] wr_word;
    logic [OUT_W-1:0] rd_word [4];
    logic             wr_fire;
    logic             rd_odd;
    logic             emit;

`ifdef JPEG_IDCT_TRANSPOSE_SAT_EN
    // In range only when every bit from the output sign bit upward agrees.
    always_comb begin
        if (&bus.inport_data_i[IN_W-1:OUT_W-1] || ~|bus.inport_data_i[IN_W-1:OUT_W-1]) begin
            wr_word = bus.inport_data_i[OUT_W-1:0];
        end else begin
            wr_word = {bus.inport_data_i[IN_W-1], {(OUT_W-1){~bus.inport_data_i[IN_W-1]}}};
        end
    end
`else
    logic unused_hi;
    assign wr_word   = bus.inport_data_i[OUT_W-1:0];
    assign unused_hi = ^bus.inport_data_i[IN_W-1:OUT_W];
`endif

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[{wr_ptr_q, bus.inport_idx_i}] <= wr_word;
        end
    end

    always_comb begin
        wr_fire  = bus.inport_valid_i && !full_q[wr_ptr_q];
        rd_odd   = (beat_q == 3'd1) || (beat_q == 3'd2) || (beat_q == 3'd3);
        emit     = 1'b0;
        state_d  = state_q;
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        col_d    = col_q;
        beat_d   = beat_q;
        valid_d  = 1'b0;
        oidx_d   = oidx_q;
        ocol_d   = ocol_q;
        ovf_d    = ovf_q | (bus.inport_valid_i && full_q[wr_ptr_q]);
        for (int k = 0; k < 4; k++) begin
            rd_word[k] = mem_q[{rd_ptr_q, 2'(k), rd_odd, col_q}];
            lane_d[k]  = lane_q[k];
        end

        if (wr_fire && bus.inport_idx_i == c_LAST_IDX) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_ptr_q] && bus.outport_accept_i) begin
                    state_d = ST_RUN;
                    col_d   = 3'd0;
                    beat_d  = 3'd0;
                end
            end
            ST_RUN: begin
                // Column 0 was already granted when the bank was taken on.
                emit = (beat_q != 3'd0) || (col_q == 3'd0) || bus.outport_accept_i;
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            oidx_d  = beat_q;
            ocol_d  = col_q;
            beat_d  = beat_q + 3'd1;
            for (int k = 0; k < 4; k++) begin
                lane_d[k] = rd_word[k];
            end
            if (beat_q == c_LAST_BEAT) begin
                col_d = col_q + 3'd1;
                if (col_q == c_LAST_COL) begin
                    full_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d         = ~rd_ptr_q;
                    if (!(full_q[~rd_ptr_q] && bus.outport_accept_i)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || img_start_i) begin
            state_q  <= ST_IDLE;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            col_q    <= 3'd0;
            beat_q   <= 3'd0;
            valid_q  <= 1'b0;
            oidx_q   <= 3'd0;
            ocol_q   <= 3'd0;
            ovf_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            col_q    <= col_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            oidx_q   <= oidx_d;
            ocol_q   <= ocol_d;
            ovf_q    <= ovf_d;
            for (int k = 0; k < 4; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

    assign bus.inport_accept_o = ~full_q[wr_ptr_q];
    assign bus.outport_valid_o = valid_q;
    assign bus.outport_idx_o   = oidx_q;
    assign bus.outport_col_o   = ocol_q;
    assign bus.outport_data0_o = lane_q[0];
    assign bus.outport_data1_o = lane_q[1];
    assign bus.outport_data2_o = lane_q[2];
    assign bus.outport_data3_o = lane_q[3];
    assign overflow_o          = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_idct_transpose.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_jpeg_idct_transpose                                          |
// | Purpose  : Scoreboard bench for the IDCT transpose buffer.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_jpeg_idct_transpose;

    typedef struct packed {
        logic [63:0] lanes;
        logic [2:0]  idx;
        logic [2:0]  col;
    } beat_t;

`ifdef JPEG_IDCT_TRANSPOSE_SAT_EN
    localparam logic [15:0] c_EXP_POS = 16'h7FFF;
    localparam logic [15:0] c_EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] c_EXP_POS = 16'h2345;
    localparam logic [15:0] c_EXP_NEG = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic img_start;
    logic overflow;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t mon_act;
    beat_t mon_exp;
    logic [31:0] blk [64];

    jpeg_idct_transpose_if #(.IN_W(32), .OUT_W(16)) bus ();

    jpeg_idct_transpose #(.IN_W(32), .OUT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .img_start_i (img_start),
        .bus         (bus),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    // Reference narrowing: signed value clamped (optionally), then low 16 bits.
    function automatic logic [15:0] ref_lane(input logic [31:0] w);
        longint v;
        v = longint'($signed(w));
`ifdef JPEG_IDCT_TRANSPOSE_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return 16'(v);
    endfunction

    task automatic push_expected();
        beat_t e;
        int    odd;
        for (int c = 0; c < 8; c++) begin
            for (int b = 0; b < 8; b++) begin
                odd     = (b >= 1 && b <= 3) ? 1 : 0;
                e.lanes = {ref_lane(blk[(0 + odd) * 8 + c]), ref_lane(blk[(2 + odd) * 8 + c]),
                           ref_lane(blk[(4 + odd) * 8 + c]), ref_lane(blk[(6 + odd) * 8 + c])};
                e.idx   = 3'(b);
                e.col   = 3'(c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.outport_valid_o === 1'b1) begin
            mon_act = {bus.outport_data0_o, bus.outport_data1_o, bus.outport_data2_o,
                       bus.outport_data3_o, bus.outport_idx_o, bus.outport_col_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got col %0d idx %0d, required no beat",
                         bus.outport_col_o, bus.outport_idx_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_c%0d_b%0d: got %h required %h",
                             mon_exp.col, mon_exp.idx, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic drive(input logic [5:0] idx, input logic [31:0] d);
        bus.inport_valid_i = 1'b1;
        bus.inport_idx_i   = idx;
        bus.inport_data_i  = d;
        @(negedge clk);
    endtask

    task automatic fill_random();
        logic [31:0] r;
        for (int i = 0; i < 64; i++) begin
            r      = $urandom;
            blk[i] = r[0] ? 32'($urandom) : {{16{r[31]}}, r[31:16]};
        end
    endtask

    // Raster order with occasional overwritten decoys and idle gaps; idx 63 last.
    task automatic send_block(input bit kept);
        if (kept) push_expected();
        for (int i = 0; i < 64; i++) begin
            if (i < 63 && $urandom_range(0, 9) == 0) drive(6'(i), 32'($urandom));
            if (i < 63 && $urandom_range(0, 9) == 0) begin
                bus.inport_valid_i = 1'b0;
                @(negedge clk);
            end
            drive(6'(i), blk[i]);
        end
        bus.inport_valid_i = 1'b0;
    endtask

    task automatic wait_beat(input int c, input int b);
        int n = 0;
        while (!(bus.outport_valid_o === 1'b1 && bus.outport_col_o == 3'(c) &&
                 bus.outport_idx_o == 3'(b)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_c%0d_b%0d", c, b), 64'(n < 2000), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.outport_valid_o !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic count_run(output int n);
        n = 0;
        while (bus.outport_valid_o === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out"}, {bus.outport_valid_o, bus.outport_idx_o, bus.outport_col_o,
                            bus.outport_data0_o, bus.outport_data1_o,
                            bus.outport_data2_o, bus.outport_data3_o}, 64'd0);
        chk({tag, "_accept"}, 64'(bus.inport_accept_o), 64'd1);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int n;
        rst                  = 1'b1;
        img_start            = 1'b0;
        bus.inport_valid_i   = 1'b0;
        bus.inport_idx_i     = 6'd0;
        bus.inport_data_i    = 32'd0;
        bus.outport_accept_i = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp block: latency and 64 contiguous beats.
        for (int i = 0; i < 64; i++) blk[i] = 32'(i);
        send_block(1'b1);
        chk("lat_e1", 64'(bus.outport_valid_o), 64'd0);
        @(negedge clk);
        chk("lat_e2", 64'(bus.outport_valid_o), 64'd0);
        @(negedge clk);
        chk("lat_first", {bus.outport_valid_o, bus.outport_idx_o, bus.outport_col_o}, 64'h40);
        count_run(n);
        chk("contig64", 64'(n), 64'd64);
        wait_drain();

        // Three blocks with downstream stalled: third dropped.
        bus.outport_accept_i = 1'b0;
        fill_random();
        send_block(1'b1);
        fill_random();
        send_block(1'b1);
        chk("accept_low", 64'(bus.inport_accept_o), 64'd0);
        fill_random();
        send_block(1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        bus.outport_accept_i = 1'b1;
        n = 0;
        while (bus.outport_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        count_run(n);
        chk("no_bubble128", 64'(n), 64'd128);
        wait_drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Accept dropped mid-column 2 holds column 3.
        fill_random();
        send_block(1'b1);
        wait_beat(2, 3);
        bus.outport_accept_i = 1'b0;
        wait_beat(2, 7);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.outport_valid_o === 1'b1) n++;
        end
        chk("col3_held", 64'(n), 64'd0);
        bus.outport_accept_i = 1'b1;
        wait_beat(3, 0);
        wait_drain();

        // Narrowing of out-of-range words.
        fill_random();
        blk[0] = 32'h0001_2345;
        blk[8] = 32'hFFFE_0000;
        send_block(1'b1);
        wait_beat(0, 0);
        chk("narrow_pos", 64'(bus.outport_data0_o), 64'(c_EXP_POS));
        @(negedge clk);
        chk("narrow_neg", 64'(bus.outport_data0_o), 64'(c_EXP_NEG));
        wait_drain();

        // img_start mid-column with both banks full and overflow set.
        bus.outport_accept_i = 1'b0;
        fill_random();
        send_block(1'b1);
        fill_random();
        send_block(1'b1);
        drive(6'd0, 32'd5);
        bus.inport_valid_i = 1'b0;
        chk("ovf_pre_flush", 64'(overflow), 64'd1);
        bus.outport_accept_i = 1'b1;
        wait_beat(4, 5);
        img_start = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        img_start = 1'b0;
        check_idle_outputs("flush");
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.outport_valid_o === 1'b1) n++;
        end
        chk("flush_silent", 64'(n), 64'd0);
        fill_random();
        send_block(1'b1);
        wait_drain();

        // Reset while writing the next block during a replay.
        fill_random();
        send_block(1'b1);
        wait_beat(1, 0);
        for (int i = 0; i < 20; i++) drive(6'(i), 32'($urandom));
        bus.inport_valid_i = 1'b1;
        bus.inport_idx_i   = 6'd20;
        rst                = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        rst                = 1'b0;
        bus.inport_valid_i = 1'b0;
        check_idle_outputs("rst_mid");
        fill_random();
        send_block(1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
